fixed_divider_seq: RTL and testbench

// - Sequential unsigned Q8.8 fixed-point divider. Inverse of the combinational fixed_multi; same 16-bit {int[7:0],frac[7:0]} format.
// - Restoring shift-subtract, one quotient bit per clock.
// - Sits beside the adder/multiplier cores in the operator datapath; start/busy/done handshake to the control FSM.

---
 rtl/fixed_divider_seq_if.sv | 29 ++
 rtl/fixed_divider_seq.sv | 168 ++++++++++++++++
 tb/tb_fixed_divider_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fixed_divider_seq_if.sv
// Operand/result bundle between the operator control FSM (master) and the
// sequential Q8.8 divider (slave).
interface fixed_divider_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         div_zero;
  logic         inexact;

  // start/busy/done handshake: start is sampled only while the divider is idle
  // (busy=0 and not in the done cycle); busy stays high from the accepting edge
  // until done rises; done is a one-cycle pulse qualifying result and all flags,
  // which then hold until the next accepted start.
  modport master (
    output start, dividend, divisor,
    input  result, busy, done, overflow, div_zero, inexact
  );

  modport slave (
    input  start, dividend, divisor,
    output result, busy, done, overflow, div_zero, inexact
  );
endinterface

// File: rtl/fixed_divider_seq.sv
// Sequential unsigned Q8.8 restoring divider, one quotient bit per clock.
// Optional round-half-up mode is enabled with `define FIXED_DIV_ROUND_EN.
module fixed_divider_seq #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fixed_divider_seq_if.slave   dif,
  output logic [1:0]           dbg_state
);
  localparam int W = INT_W + FRAC_W;
`ifdef FIXED_DIV_ROUND_EN
  // One extra iteration produces a guard bit below the result LSB.
  localparam int NW = W + FRAC_W + 1;
`else
  localparam int NW = W + FRAC_W;
`endif
  localparam int CNT_W = $clog2(NW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     q_q, q_d;
  logic [W-1:0]      rem_q, rem_d;
  logic [W-1:0]      dsr_q, dsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              dz_q, dz_d;
  logic              inx_q, inx_d;

  logic [W:0]        rem_sh;
  logic              ge;
  logic [W-1:0]      diff;
  logic              ovf_calc;
  logic [W-1:0]      res_calc;
  logic              inx_calc;
`ifdef FIXED_DIV_ROUND_EN
  logic [NW-1:0]     round_sum;
`endif

  // Partial remainder shifted left with the next numerator bit.
  assign rem_sh = {rem_q, n_q[NW-1]};
  assign ge     = rem_sh >= {1'b0, dsr_q};
  // Only used when ge holds, so the true difference always fits in W bits.
  assign diff   = rem_sh[W-1:0] - dsr_q;

`ifdef FIXED_DIV_ROUND_EN
  assign round_sum = {1'b0, q_q[NW-1:1]} + {{(NW-1){1'b0}}, q_q[0]};
  assign ovf_calc  = |round_sum[NW-1:W];
  assign res_calc  = ovf_calc ? {W{1'b1}} : round_sum[W-1:0];
  assign inx_calc  = q_q[0] | (rem_q != '0);
`else
  assign ovf_calc  = |q_q[NW-1:W];
  assign res_calc  = ovf_calc ? {W{1'b1}} : q_q[W-1:0];
  assign inx_calc  = rem_q != '0;
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    q_d      = q_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    inx_d    = inx_q;

    case (state_q)
      S_IDLE: begin
        // done_q high means this is the done cycle: starts are not taken yet.
        if (dif.start && !done_q) begin
          dsr_d  = dif.divisor;
          n_d    = {dif.dividend, {(NW-W){1'b0}}};
          q_d    = '0;
          rem_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          ovf_d  = 1'b0;
          dz_d   = 1'b0;
          inx_d  = 1'b0;
          state_d = (dif.divisor == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        n_d   = n_q << 1;
        q_d   = {q_q[NW-2:0], ge};
        rem_d = ge ? diff : rem_sh[W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NW-1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dsr_q == '0) begin
          result_d = {W{1'b1}};
          dz_d     = 1'b1;
          ovf_d    = 1'b0;
          inx_d    = 1'b0;
        end else begin
          result_d = res_calc;
          ovf_d    = ovf_calc;
          inx_d    = inx_calc;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      inx_q    <= inx_d;
    end
  end

  assign dif.result   = result_q;
  assign dif.busy     = busy_q;
  assign dif.done     = done_q;
  assign dif.overflow = ovf_q;
  assign dif.div_zero = dz_q;
  assign dif.inexact  = inx_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_fixed_divider_seq.sv
// Scoreboard bench for fixed_divider_seq: directed Q8.8 vectors with
// hand-computed quotients, flags and start-to-done latency.
module tb_fixed_divider_seq;
  localparam int W = 16;
`ifdef FIXED_DIV_ROUND_EN
  localparam int LAT = 26;
  localparam logic [W-1:0] TWO_THIRDS = 16'h00AB;
`else
  localparam int LAT = 25;
  localparam logic [W-1:0] TWO_THIRDS = 16'h00AA;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  fixed_divider_seq_if #(.W(W)) dif ();

  fixed_divider_seq dut (
    .clk       (clk),
    .rst       (rst),
    .dif       (dif),
    .dbg_state (dbg_state)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_flg_q[$];   // {overflow, div_zero, inexact}
  int           exp_lat_q[$];
  int           start_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                       input logic [W-1:0] exp_res, input logic [2:0] exp_flg,
                       input int lat);
    @(negedge clk);
    dif.dividend = dvd;
    dif.divisor  = dsr;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    exp_q.push_back(exp_res);
    exp_flg_q.push_back(exp_flg);
    exp_lat_q.push_back(lat);
    start_q.push_back(edge_cnt);
    check("busy_after_start", {31'b0, dif.busy}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!dif.busy && !dif.done) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dif.done) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_done_timeout", {31'b0, ok}, 32'd1);
  endtask

  // ---------------- monitor ----------------
  bit pulse_chk = 1'b0;
  always @(negedge clk) begin
    if (pulse_chk) begin
      check("done_pulse_width", {31'b0, dif.done}, 32'd0);
      pulse_chk = 1'b0;
    end
    if (!rst && dif.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] er;
        logic [2:0]   ef;
        int           el, st;
        er = exp_q.pop_front();
        ef = exp_flg_q.pop_front();
        el = exp_lat_q.pop_front();
        st = start_q.pop_front();
        check("result",   {16'b0, dif.result},   {16'b0, er});
        check("overflow", {31'b0, dif.overflow}, {31'b0, ef[2]});
        check("div_zero", {31'b0, dif.div_zero}, {31'b0, ef[1]});
        check("inexact",  {31'b0, dif.inexact},  {31'b0, ef[0]});
        check("busy_at_done", {31'b0, dif.busy}, 32'd0);
        check("latency", edge_cnt - st, el);
        pulse_chk = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result",   {16'b0, dif.result}, 32'd0);
    check("rst_busy",     {31'b0, dif.busy},   32'd0);
    check("rst_done",     {31'b0, dif.done},   32'd0);
    check("rst_flags",    {29'b0, dif.overflow, dif.div_zero, dif.inexact}, 32'd0);
    check("rst_state",    {30'b0, dbg_state},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: {dividend, divisor, expected result, {ovf,dz,inx}}.
    issue(16'h0300, 16'h0200, 16'h0180, 3'b000, LAT); wait_idle(60);
    issue(16'h0200, 16'h0300, TWO_THIRDS, 3'b001, LAT); wait_idle(60);
    issue(16'h8000, 16'h0040, 16'hFFFF, 3'b100, LAT); wait_idle(60);
    issue(16'hFFFF, 16'h0100, 16'hFFFF, 3'b000, LAT); wait_idle(60);
    issue(16'h1234, 16'h0000, 16'hFFFF, 3'b010, 1);   wait_idle(60);
    issue(16'h0001, 16'hFFFF, 16'h0000, 3'b001, LAT); wait_idle(60);
    issue(16'h0100, 16'h0100, 16'h0100, 3'b000, LAT); wait_idle(60);
    issue(16'h00FF, 16'h0001, 16'hFF00, 3'b000, LAT); wait_idle(60);
    issue(16'h0100, 16'h0001, 16'hFFFF, 3'b100, LAT); wait_idle(60);

    // Start during RUN is ignored; the original operands decide the result.
    issue(16'h0100, 16'h0400, 16'h0040, 3'b000, LAT);
    repeat (5) @(negedge clk);
    dif.dividend = 16'h0900;
    dif.divisor  = 16'h0300;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check("run_start_busy", {31'b0, dif.busy}, 32'd1);
    check("run_start_state", {30'b0, dbg_state}, 32'd1);

    // Start held during the done cycle is ignored too.
    wait_done(60);
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check("done_cycle_start_busy", {31'b0, dif.busy}, 32'd0);
    wait_idle(10);
    issue(16'h0900, 16'h0300, 16'h0300, 3'b000, LAT); wait_idle(60);

    // Asynchronous reset in the middle of a division.
    issue(16'h0300, 16'h0200, 16'h0180, 3'b000, LAT);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_result", {16'b0, dif.result}, 32'd0);
    check("midrst_busy",   {31'b0, dif.busy},   32'd0);
    check("midrst_done",   {31'b0, dif.done},   32'd0);
    check("midrst_flags",  {29'b0, dif.overflow, dif.div_zero, dif.inexact}, 32'd0);
    check("midrst_state",  {30'b0, dbg_state},  32'd0);
    exp_q.delete();
    exp_flg_q.delete();
    exp_lat_q.delete();
    start_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(16'h0200, 16'h0300, TWO_THIRDS, 3'b001, LAT); wait_idle(60);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
